// File: rtl/cmul_arbiter_pkg.sv
// Shared types and helpers for the complex-multiplier arbiter: operand slicing,
// default width, requester-index width and the response register state.
package cmul_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_HALF  = DEFAULT_WIDTH / 2;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Index width for n requesters; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [DEFAULT_HALF-1:0] re(input logic [DEFAULT_WIDTH-1:0] v);
        return v[DEFAULT_WIDTH-1:DEFAULT_HALF];
    endfunction

    function automatic logic signed [DEFAULT_HALF-1:0] im(input logic [DEFAULT_WIDTH-1:0] v);
        return v[DEFAULT_HALF-1:0];
    endfunction

endpackage

// File: rtl/cmul_arbiter_cmult.sv
// Combinational complex multiplier on packed {real, imag} halves; products are
// exact at WIDTH bits, sum and difference wrap modulo 2^WIDTH.
module ComplexMultiplier #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    localparam int H = WIDTH / 2;

    logic signed [WIDTH-1:0] w_ar, w_ai, w_br, w_bi;
    logic signed [WIDTH-1:0] w_rr, w_ii, w_ri, w_ir;

    assign w_ar = {{H{a[WIDTH-1]}}, a[WIDTH-1:H]};
    assign w_ai = {{H{a[H-1]}},     a[H-1:0]};
    assign w_br = {{H{b[WIDTH-1]}}, b[WIDTH-1:H]};
    assign w_bi = {{H{b[H-1]}},     b[H-1:0]};

    assign w_rr = w_ar * w_br;
    assign w_ii = w_ai * w_bi;
    assign w_ri = w_ar * w_bi;
    assign w_ir = w_ai * w_br;

    assign p = {w_rr - w_ii, w_ri + w_ir};

endmodule

// File: rtl/cmul_arbiter_rr_select.sv
// Round-robin priority selector: first asserted request at or after ptr,
// wrapping modulo N (N is a power of two, so index arithmetic wraps naturally).
module rr_select
    import cmul_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] winner
);

    logic [IW-1:0] w_idx;

    // Scan from the farthest offset down so the nearest match is written last.
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
        w_idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = ptr + IW'(k);
            if (req[w_idx]) begin
                grant_valid = 1'b1;
                winner      = w_idx;
            end
        end
    end

endmodule

// File: rtl/cmul_arbiter.sv
// Round-robin arbiter sharing one complex multiplier among N_REQ requesters,
// with a single registered response slot and a completed-operation counter.
module cmul_arbiter
    import cmul_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IW    = idx_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_result,
    output logic [IW-1:0]          rsp_id,
    output logic [31:0]            op_count,
    output rsp_state_e             o_dbg_state
);

    rsp_state_e         r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_id;
    logic [2*WIDTH-1:0] r_result;
    logic [31:0]        r_op_count;

    logic               w_can_accept;
    logic               w_any_valid;
    logic               w_grant;
    logic [IW-1:0]      w_winner;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [2*WIDTH-1:0] w_prod;

    // rsp_ready reaches req_ready combinationally so a draining slot refills in the same cycle.
    assign w_can_accept = (r_state == RSP_EMPTY) || rsp_ready;
    assign w_grant      = w_any_valid && w_can_accept && !rst;

    rr_select #(.N(N_REQ)) u_sel (
        .req         (req_valid),
        .ptr         (r_ptr),
        .grant_valid (w_any_valid),
        .winner      (w_winner)
    );

    assign w_a = req_a[int'(w_winner)*WIDTH +: WIDTH];
    assign w_b = req_b[int'(w_winner)*WIDTH +: WIDTH];

    ComplexMultiplier #(.WIDTH(WIDTH)) u_cmul (
        .a (w_a),
        .b (w_b),
        .p (w_prod)
    );

    always_comb begin
        req_ready = '0;
        if (w_grant) req_ready[w_winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RSP_EMPTY;
            r_ptr      <= '0;
            r_id       <= '0;
            r_result   <= '0;
            r_op_count <= '0;
        end else begin
            if (w_grant) begin
                r_state  <= RSP_FULL;
                r_result <= w_prod;
                r_id     <= w_winner;
                r_ptr    <= w_winner + IW'(1);
            end else if (rsp_ready) begin
                r_state  <= RSP_EMPTY;
            end
            if ((r_state == RSP_FULL) && rsp_ready) r_op_count <= r_op_count + 32'd1;
        end
    end

    assign rsp_valid   = (r_state == RSP_FULL);
    assign rsp_result  = r_result;
    assign rsp_id      = r_id;
    assign op_count    = r_op_count;
    assign o_dbg_state = r_state;

endmodule

// File: doc/cmul_arbiter.md
# cmul_arbiter

Round-robin arbiter that shares one combinational `ComplexMultiplier` among `N_REQ` requesters in the CMS unit. Each requester offers a packed complex operand pair through a valid/ready handshake. The arbiter selects one request per cycle, registers the product together with the requester index, and presents it on a single response port with backpressure. A free-running completed-operation counter supports performance monitoring.

## Interface
- `N_REQ`, default 4: number of requesters; power of two, 2..8.
- `WIDTH`, default 32: packed operand width. Operand layout is real = `[WIDTH-1:WIDTH/2]`, imag = `[WIDTH/2-1:0]`, both two's complement.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: per-requester accept; at most one bit high per cycle.
- `req_a` in `N_REQ*WIDTH`: operand a of requester i at `[i*WIDTH +: WIDTH]`.
- `req_b` in `N_REQ*WIDTH`: operand b, same slicing as `req_a`.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out `2*WIDTH`: real at `[2*WIDTH-1:WIDTH]`, imag at `[WIDTH-1:0]`.
- `rsp_id` out `clog2(N_REQ)`: index of the requester that owns `rsp_result`.
- `op_count` out 32: number of completed response handshakes; wraps modulo 2^32.

## Operation
- **Arithmetic.** `real = ar*br - ai*bi` and `imag = ar*bi + ai*br`. Each product is a full `WIDTH`-bit signed value. Sum and difference are truncated modulo 2^`WIDTH` (wrap, no saturation).
- **Output register states.** There are two: EMPTY (`rsp_valid=0`) and FULL (`rsp_valid=1`).
  - `can_accept = !rsp_valid || rsp_ready`.
  - `can_accept` is a combinational path from `rsp_ready` to `req_ready`. This path is intentional.
- **Grant.**
  - When `can_accept` is high, the winner is the first `i` with `req_valid[i]=1`, searching from `ptr` upward and wrapping modulo `N_REQ`.
  - `req_ready[winner]=1`; every other `req_ready` bit is 0.
  - When no requester is valid or `can_accept=0`, all `req_ready` bits are 0.
  - `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Pointer.** On a grant, `ptr <= (winner+1) mod N_REQ`. Otherwise `ptr` holds its value.
- **Transitions.**
  - EMPTY + grant -> FULL, with `rsp_result`/`rsp_id` loaded.
  - FULL + `rsp_ready` + grant -> FULL, with new data loaded (back-to-back).
  - FULL + `rsp_ready` + no grant -> EMPTY.
  - FULL + `!rsp_ready` -> FULL, with `rsp_result`/`rsp_id` held stable.
- **Counter.** `op_count` increments on every cycle where `rsp_valid && rsp_ready`.
- **Requester contract.** A requester holds `req_a`/`req_b` stable while `req_valid=1 && req_ready=0`.

## Timing
- **Reset values.** `rsp_valid=0`, `rsp_result=0`, `rsp_id=0`, `op_count=0`, `ptr=0` (requester 0 has highest priority). All `req_ready` bits are 0 during reset.
- **Latency.** A request accepted at edge T appears with `rsp_valid=1` in the cycle after T, i.e. one-cycle latency.
- **Throughput.** One operation per cycle while `rsp_ready=1`.
- **Fairness.** With all requesters continuously valid, each is granted exactly once every `N_REQ` grants.
- **Stalled response.** With `rsp_ready=0` and FULL, no grants occur and `op_count` is unchanged.
- **Reset mid-operation.** A response still in the register is discarded without a handshake. Requests pending at reset are not accepted. After reset is released, arbitration restarts at requester 0.
- **Counter wrap.** `0xFFFFFFFF` + 1 -> 0.

## Structure
- **Shared package.**
  - Operand/result packing helpers: `re`/`im` slice functions.
  - Default `WIDTH`.
  - Requester-index width function `clog2(N_REQ)`.
- **Sub-modules.**
  - One `ComplexMultiplier #(.WIDTH(WIDTH))` instance, fed by the winner's mux output.
  - The round-robin priority selector is a natural sub-module, `rr_select` (inputs `req`, `ptr`; outputs `grant_valid`, `winner`). It is reused elsewhere.
- **Size.** 150-250 lines total.

## Test plan
- **Basic product.** Requester 2 sends a = {3, 4}, b = {1, 2}; `rsp_ready=1` -> the next cycle shows `rsp_valid=1`, `rsp_id=2`, `rsp_result` = {`0xFFFFFFFB`, `0x0000000A`} (-5 + 10j), and `op_count=1`.
- **Round-robin fairness.** All 4 requesters continuously valid, `rsp_ready=1` -> `rsp_id` sequence 0,1,2,3,0,1,2,3 on consecutive cycles, with exactly one `req_ready` bit high per cycle.
- **Backpressure.** A request is accepted, then `rsp_ready=0` for 3 cycles -> `rsp_result`/`rsp_id` are stable, all `req_ready` bits are 0, and `op_count` is unchanged. When `rsp_ready` returns to 1, the next grant occurs in that same cycle (back-to-back).
- **Wrap arithmetic.** a = b = {-32768, -32768} -> real = 0, imag = `0x80000000` (wrapped); also compare 1000 random operand pairs against a reference model.
- **Reset mid-operation.** Assert `rst` while FULL with `rsp_ready=0` -> `rsp_valid`, `rsp_result`, `rsp_id`, and `op_count` all go to 0 immediately, asynchronously. After release with requesters 1 and 3 valid, requester 1 is granted first.
- **Pointer skip.** Only requesters 3 and 1 are valid and `ptr=2` -> requester 3 is granted, then requester 1.
